// File: rtl/ami_channel_merge_pkg.sv
// Shared request type and sizing constants for the per-channel merge stage.
package ami_channel_merge_pkg;

  localparam int AMI_NUM_PORTS    = 2;
  localparam int AMI_NUM_APPS     = 2;
  localparam int AMI_NUM_CHANNELS = 4;

  localparam int AMI_ADDR_W = 64;
  localparam int AMI_DATA_W = 64;
  localparam int AMI_SIZE_W = 8;
  localparam int AMI_APP_W  = (AMI_NUM_APPS > 1) ? $clog2(AMI_NUM_APPS) : 1;
  localparam int AMI_PORT_W = (AMI_NUM_PORTS > 1) ? $clog2(AMI_NUM_PORTS) : 1;
  localparam int AMI_CHAN_W = (AMI_NUM_CHANNELS > 1) ? $clog2(AMI_NUM_CHANNELS) : 1;

  localparam int CHMERGE_Q_DEPTH  = 3;
  localparam int CHMERGE_IDX_BITS = $clog2(AMI_NUM_PORTS * AMI_NUM_APPS);

  typedef struct packed {
    logic                  valid;
    logic [AMI_ADDR_W-1:0] addr;
    logic [AMI_DATA_W-1:0] data;
    logic [AMI_SIZE_W-1:0] size;
    logic                  isWrite;
    logic [AMI_APP_W-1:0]  srcApp;
    logic [AMI_PORT_W-1:0] srcPort;
    logic [AMI_CHAN_W-1:0] channel;
  } AMIReq;

  // Index width that stays legal for a single-source instance.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ami_channel_merge_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after rr_ptr, wrapping.
module ami_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int off = 0; off < N; off++) begin
      idx = IDX_W'((int'(rr_ptr) + off) % N);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/ami_channel_merge.sv
// Per-channel merge: round-robin over sources into a small FIFO feeding the DRAM controller.
// Optional per-source / full-stall counters under AMI_CHMERGE_STATS_EN.
module ami_channel_merge
  import ami_channel_merge_pkg::*;
#(
  parameter int NUM_PORTS  = AMI_NUM_PORTS * AMI_NUM_APPS,
  parameter int CHANNEL_ID = 0,
  parameter int LOG_DEPTH  = CHMERGE_Q_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enabled,
  input  AMIReq [NUM_PORTS-1:0]       req_in,
  output logic  [NUM_PORTS-1:0]       req_grant_out,
  output AMIReq                       mem_req_out,
  input  logic                        mem_req_grant_in,
  output logic                        err_chan_mismatch,
  output logic  [NUM_PORTS-1:0][31:0] stat_grants,
  output logic  [31:0]                stat_full_cycles
);

  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam int IDX_W = idx_bits(NUM_PORTS);

  logic [NUM_PORTS-1:0] eligible, mismatch, arb_req, arb_grant;
  logic [IDX_W-1:0]     arb_idx, rr_ptr_q, rr_ptr_d;
  logic                 arb_any, full, push, pop;

  AMIReq                q_mem_q [DEPTH];
  AMIReq                q_mem_d [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LOG_DEPTH:0]   count_q, count_d;
  logic                 err_q, err_d;

  always_comb begin
    eligible = '0;
    mismatch = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      eligible[i] = req_in[i].valid && (req_in[i].channel == AMI_CHAN_W'(CHANNEL_ID));
      mismatch[i] = req_in[i].valid && (req_in[i].channel != AMI_CHAN_W'(CHANNEL_ID));
    end
  end

  // A full queue blocks the grant even if the head leaves this cycle; no grants during reset.
  assign full    = (count_q == (LOG_DEPTH+1)'(DEPTH));
  assign arb_req = (enabled && !full && rst_n) ? eligible : '0;

  ami_rr_arbiter #(.N(NUM_PORTS), .IDX_W(IDX_W)) u_arb (
    .req       (arb_req),
    .rr_ptr    (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  assign req_grant_out = arb_grant;
  assign push          = arb_any;
  assign pop           = (count_q != '0) && mem_req_grant_in;

  always_comb begin
    q_mem_d  = q_mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rr_ptr_d = rr_ptr_q;
    err_d    = err_q | (|mismatch);
    if (push) begin
      q_mem_d[wr_ptr_q] = req_in[arb_idx];
      wr_ptr_d          = wr_ptr_q + 1'b1;
      rr_ptr_d          = (arb_idx == IDX_W'(NUM_PORTS-1)) ? '0 : arb_idx + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset: count_q alone decides what is visible.
  always_ff @(posedge clk) begin
    q_mem_q <= q_mem_d;
  end

  always_comb begin
    mem_req_out       = q_mem_q[rd_ptr_q];
    mem_req_out.valid = (count_q != '0);
  end

  assign err_chan_mismatch = err_q;

`ifdef AMI_CHMERGE_STATS_EN
  logic [NUM_PORTS-1:0][31:0] stat_grants_q, stat_grants_d;
  logic [31:0]                stat_full_q, stat_full_d;

  always_comb begin
    stat_grants_d = stat_grants_q;
    stat_full_d   = stat_full_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (arb_grant[i] && (stat_grants_q[i] != 32'hFFFF_FFFF))
        stat_grants_d[i] = stat_grants_q[i] + 32'd1;
    end
    if (enabled && full && (|eligible) && (stat_full_q != 32'hFFFF_FFFF))
      stat_full_d = stat_full_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_grants_q <= '0;
      stat_full_q   <= '0;
    end else begin
      stat_grants_q <= stat_grants_d;
      stat_full_q   <= stat_full_d;
    end
  end

  assign stat_grants      = stat_grants_q;
  assign stat_full_cycles = stat_full_q;
`else
  assign stat_grants      = '0;
  assign stat_full_cycles = '0;
`endif

endmodule
